// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel memory-mapped engine.
// Holds FSM state encoding, output mode codes and PIX_W-derived widths.
package sobel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_CALC    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] MODE_HALF   = 2'd0;
    localparam logic [1:0] MODE_FULL   = 2'd1;
    localparam logic [1:0] MODE_THRESH = 2'd2;
    localparam logic [1:0] MODE_ALT    = 2'd3;

    function automatic int bpp(input int pix_w);
        return (pix_w + 7) / 8;
    endfunction

    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two row buffers feeding the top and middle rows of the 3x3 window.
// Both rows shift down at column x on a single write enable.
module sobel_line_buffer #(
    parameter int IMG_W = 256,
    parameter int PIX_W = 8,
    parameter int XW    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [XW-1:0]    x_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] top_o,
    output logic [PIX_W-1:0] mid_o
);

    logic [PIX_W-1:0] top_q [IMG_W];
    logic [PIX_W-1:0] mid_q [IMG_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IMG_W; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
            end
        end else if (we_i) begin
            top_q[x_i] <= mid_q[x_i];
            mid_q[x_i] <= din_i;
        end
    end

    assign top_o = top_q[x_i];
    assign mid_o = mid_q[x_i];

endmodule

// File: rtl/sobel_mm_engine.sv
// Sobel edge engine: one read per input pixel through two line buffers,
// one packed gradient write per interior pixel, Avalon-MM master side.
module sobel_mm_engine
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [1:0]        mode,
    input  logic [PIX_W+2:0]  threshold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [PIX_W-1:0]  writedata,
    input  logic [PIX_W-1:0]  readdata,
    input  logic              waitrequest
);

    localparam int BPP = bpp(PIX_W);
    localparam int GW  = grad_w(PIX_W);
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);

    localparam logic [XW-1:0]    X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]    Y_LAST = YW'(IMG_H - 1);
    localparam logic [PIX_W-1:0] MAXP   = '1;
    localparam logic [GW-1:0]    MAXG   = GW'((1 << PIX_W) - 1);

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d, x_nx;
    logic [YW-1:0]       y_q, y_d, y_nx;
    logic [ADDR_W-1:0]   in_base_q, in_base_d;
    logic [ADDR_W-1:0]   out_base_q, out_base_d;
    logic [1:0]          mode_q, mode_d;
    logic [GW-1:0]       thr_q, thr_d;
    logic [PIX_W-1:0]    wdata_q, wdata_d;
    logic [2:0][2:0][PIX_W-1:0] win_q;

    logic [PIX_W-1:0]    lb_top, lb_mid;
    logic                lb_we;
    logic                win_ok, last_px;

    assign lb_we = (state_q == ST_CAPTURE);

    sobel_line_buffer #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W),
        .XW    (XW)
    ) u_lb (
        .clk_i  (clk),
        .rst_ni (rst),
        .we_i   (lb_we),
        .x_i    (x_q),
        .din_i  (readdata),
        .top_o  (lb_top),
        .mid_o  (lb_mid)
    );

    // Gradient from the window: left minus right, top minus bottom.
    logic [GW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [GW-1:0] gx, gy, ax, ay, s, sh;
    logic [PIX_W-1:0] pix_out;

    always_comb begin
        gx_pos = GW'(win_q[0][0]) + (GW'(win_q[1][0]) << 1) + GW'(win_q[2][0]);
        gx_neg = GW'(win_q[0][2]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[2][2]);
        gy_pos = GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2]);
        gy_neg = GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]);
        gx     = gx_pos - gx_neg;
        gy     = gy_pos - gy_neg;
        ax     = gx[GW-1] ? -gx : gx;
        ay     = gy[GW-1] ? -gy : gy;
        s      = ax + ay;
        sh     = s >> 1;
        unique case (mode_q)
            MODE_FULL:   pix_out = (s > MAXG) ? MAXP : s[PIX_W-1:0];
            MODE_THRESH: pix_out = (s >= thr_q) ? MAXP : '0;
            default:     pix_out = (sh > MAXG) ? MAXP : sh[PIX_W-1:0];
        endcase
    end

    assign win_ok  = (x_q >= XW'(2)) && (y_q >= YW'(2));
    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);
    assign x_nx    = (x_q == X_LAST) ? '0 : x_q + 1'b1;
    assign y_nx    = (x_q == X_LAST) ? y_q + 1'b1 : y_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        mode_d     = mode_q;
        thr_d      = thr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    in_base_d  = in_base;
                    out_base_d = out_base;
                    mode_d     = mode;
                    thr_d      = threshold;
                    x_d        = '0;
                    y_d        = '0;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                if (!waitrequest) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (win_ok) begin
                    state_d = ST_CALC;
                end else begin
                    x_d     = x_nx;
                    y_d     = y_nx;
                    state_d = ST_READ;
                end
            end
            ST_CALC: begin
                wdata_d = pix_out;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!waitrequest) begin
                    if (last_px) begin
                        state_d = ST_DONE;
                    end else begin
                        x_d     = x_nx;
                        y_d     = y_nx;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            mode_q     <= '0;
            thr_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            mode_q     <= mode_d;
            thr_q      <= thr_d;
            wdata_q    <= wdata_d;
        end
    end

    // New column enters on the right; older columns slide left.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb_top;
            win_q[1][2] <= lb_mid;
            win_q[2][2] <= readdata;
        end
    end

    logic [ADDR_W-1:0] rd_off, wr_off;

    assign rd_off = (ADDR_W'(y_q) * ADDR_W'(IMG_W) + ADDR_W'(x_q))
                    * ADDR_W'(BPP);
    assign wr_off = ((ADDR_W'(y_q) - ADDR_W'(2)) * ADDR_W'(IMG_W - 2)
                    + (ADDR_W'(x_q) - ADDR_W'(2))) * ADDR_W'(BPP);

    assign read      = (state_q == ST_READ);
    assign write     = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign writedata = wdata_q;
    assign address   = read  ? in_base_q + rd_off :
                       write ? out_base_q + wr_off : '0;

endmodule

// File: tb/tb_sobel_mm_engine.sv
// Directed bench for sobel_mm_engine on an 8x6 image with a memory model,
// a write/read scoreboard and optional random waitrequest stalls.
module tb_sobel_mm_engine;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 8;
    localparam int AW = 32;
    localparam int NPIX = W * H;
    localparam int FRAME_CYC = 2 * W * H + 2 * (W - 2) * (H - 2) + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic [AW-1:0] in_base = '0;
    logic [AW-1:0] out_base = '0;
    logic [1:0]    mode = '0;
    logic [PW+2:0] threshold = '0;
    logic          busy, done, read, write;
    logic [AW-1:0] address;
    logic [PW-1:0] writedata;
    logic [PW-1:0] readdata = '0;
    logic          waitrequest = 1'b0;

    always #5 clk = ~clk;

    sobel_mm_engine #(
        .IMG_W  (W),
        .IMG_H  (H),
        .PIX_W  (PW),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .in_base     (in_base),
        .out_base    (out_base),
        .mode        (mode),
        .threshold   (threshold),
        .busy        (busy),
        .done        (done),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    logic [7:0] mem [0:4095];
    int img [0:H-1][0:W-1];
    int vectors = 0;
    int miscompares = 0;
    bit stall_en = 1'b0;

    logic [AW-1:0] rd_obs [$];
    logic [AW-1:0] wa_obs [$];
    logic [PW-1:0] wd_obs [$];
    int overlap = 0;
    int unstable = 0;
    int done_seen = 0;

    logic          rd_acc_s = 1'b0;
    logic [AW-1:0] addr_s = '0;
    logic          prev_stall = 1'b0;
    logic          prev_rd = 1'b0;
    logic          prev_wr = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [PW-1:0] prev_wd = '0;

    // Bus monitor: records accepted requests and protocol violations.
    always @(negedge clk) begin
        rd_acc_s <= rst && read && !waitrequest;
        addr_s   <= address;
        if (rst) begin
            if (read && write) overlap <= overlap + 1;
            if (prev_stall && (read !== prev_rd || write !== prev_wr ||
                address !== prev_addr || (write && writedata !== prev_wd)))
                unstable <= unstable + 1;
            if (read && !waitrequest) rd_obs.push_back(address);
            if (write && !waitrequest) begin
                wa_obs.push_back(address);
                wd_obs.push_back(writedata);
            end
            if (done) done_seen <= done_seen + 1;
            prev_stall <= (read || write) && waitrequest;
            prev_rd    <= read;
            prev_wr    <= write;
            prev_addr  <= address;
            prev_wd    <= writedata;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Slave side: data one cycle after acceptance, junk otherwise.
    always @(posedge clk) begin
        #1;
        readdata    <= rd_acc_s ? mem[addr_s[11:0]] : PW'($urandom);
        waitrequest <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    logic [AW-1:0] exp_ra [$];
    logic [AW-1:0] exp_wa [$];
    logic [PW-1:0] exp_wd [$];
    int rd_mark = 0;
    int wr_mark = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_img(input int kind, input logic [AW-1:0] ib);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (kind)
                    0:       img[y][x] = (x >= W / 2) ? 255 : 0;
                    1:       img[y][x] = 100;
                    2:       img[y][x] = 10 * (y + 1);
                    default: img[y][x] = int'($urandom_range(0, 255));
                endcase
                mem[ib + AW'(y * W + x)] = 8'(img[y][x]);
            end
        end
    endtask

    function automatic int ref_pix(input int ox, input int oy,
                                   input logic [1:0] md, input int th);
        int gx, gy, s;
        gx = (img[oy][ox] + 2 * img[oy+1][ox] + img[oy+2][ox])
           - (img[oy][ox+2] + 2 * img[oy+1][ox+2] + img[oy+2][ox+2]);
        gy = (img[oy][ox] + 2 * img[oy][ox+1] + img[oy][ox+2])
           - (img[oy+2][ox] + 2 * img[oy+2][ox+1] + img[oy+2][ox+2]);
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        case (md)
            2'd1:    return (s > 255) ? 255 : s;
            2'd2:    return (s >= th) ? 255 : 0;
            default: return (s / 2 > 255) ? 255 : s / 2;
        endcase
    endfunction

    task automatic push_exp(input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                            input logic [1:0] md, input int th);
        for (int i = 0; i < NPIX; i++) exp_ra.push_back(ib + AW'(i));
        for (int oy = 0; oy < H - 2; oy++) begin
            for (int ox = 0; ox < W - 2; ox++) begin
                exp_wa.push_back(ob + AW'(oy * (W - 2) + ox));
                exp_wd.push_back(PW'(ref_pix(ox, oy, md, th)));
            end
        end
    endtask

    task automatic setup(input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                         input logic [1:0] md, input int th);
        in_base   = ib;
        out_base  = ob;
        mode      = md;
        threshold = (PW+3)'(th);
    endtask

    // Called at a negedge in IDLE; n counts cycles from go sample to done.
    task automatic run(input bit hold, output int n);
        n  = 1;
        go = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!hold) go = 1'b0;
        end while (!done && n < 4000);
        check("done_reached", done, 1'b1);
    endtask

    task automatic verify(input string tag);
        int nr;
        int nw;
        logic [AW-1:0] a;
        logic [PW-1:0] d;
        nr = exp_ra.size();
        nw = exp_wa.size();
        check({tag, "_nread"}, rd_obs.size() - rd_mark, nr);
        check({tag, "_nwrite"}, wa_obs.size() - wr_mark, nw);
        for (int i = 0; i < nr; i++) begin
            a = (rd_mark + i < rd_obs.size()) ? rd_obs[rd_mark + i] : 'x;
            check($sformatf("%s_raddr%0d", tag, i), a, exp_ra.pop_front());
        end
        for (int i = 0; i < nw; i++) begin
            a = (wr_mark + i < wa_obs.size()) ? wa_obs[wr_mark + i] : 'x;
            d = (wr_mark + i < wd_obs.size()) ? wd_obs[wr_mark + i] : 'x;
            check($sformatf("%s_waddr%0d", tag, i), a, exp_wa.pop_front());
            check($sformatf("%s_wdata%0d", tag, i), d, exp_wd.pop_front());
        end
        rd_mark = rd_obs.size();
        wr_mark = wa_obs.size();
    endtask

    // One frame at zero stall: cycle count, done pulse, busy release.
    task automatic frame(input string tag, input bit chk_cyc);
        int n;
        int d0;
        d0 = done_seen;
        run(1'b0, n);
        if (chk_cyc) check({tag, "_cycles"}, n, FRAME_CYC);
        @(negedge clk);
        check({tag, "_busy_after"}, {busy, done}, 2'b00);
        check({tag, "_done_once"}, done_seen - d0, 1);
        verify(tag);
    endtask

    initial begin
        int n;
        int k;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, done, read, write, address, writedata}, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        load_img(0, 'h100);
        setup('h100, 'h800, 2'd0, 0);
        push_exp('h100, 'h800, 2'd0, 0);
        frame("vedge", 1'b1);

        load_img(1, 'h200);
        setup('h200, 'h900, 2'd1, 0);
        push_exp('h200, 'h900, 2'd1, 0);
        frame("uniform", 1'b1);

        load_img(2, 'h300);
        setup('h300, 'hA00, 2'd2, 80);
        push_exp('h300, 'hA00, 2'd2, 80);
        frame("ramp_t80", 1'b1);
        setup('h300, 'hA00, 2'd2, 81);
        push_exp('h300, 'hA00, 2'd2, 81);
        frame("ramp_t81", 1'b1);

        load_img(3, 'h400);
        setup('h400, 'hB00, 2'd3, 0);
        push_exp('h400, 'hB00, 2'd3, 0);
        frame("rand_m3", 1'b1);

        stall_en = 1'b1;
        load_img(3, 'h500);
        setup('h500, 'hC00, 2'd1, 0);
        push_exp('h500, 'hC00, 2'd1, 0);
        frame("stall_m1", 1'b0);
        load_img(3, 'h600);
        setup('h600, 'hD00, 2'd0, 0);
        push_exp('h600, 'hD00, 2'd0, 0);
        frame("stall_m0", 1'b0);
        stall_en = 1'b0;
        repeat (3) @(negedge clk);
        check("no_overlap", overlap, 0);
        check("stall_stable", unstable, 0);

        load_img(3, 'h100);
        setup('h100, 'h800, 2'd1, 0);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!write && k < 500);
        check("rst_reach_write", write, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_mid_outs", {busy, done, read, write, address, writedata}, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd_mark = rd_obs.size();
        wr_mark = wa_obs.size();
        load_img(3, 'h200);
        setup('h200, 'h900, 2'd0, 0);
        push_exp('h200, 'h900, 2'd0, 0);
        frame("after_rst", 1'b1);

        load_img(2, 'h300);
        push_exp('h300, 'hA00, 2'd2, 80);
        load_img(0, 'h500);
        push_exp('h500, 'hC00, 2'd0, 0);
        setup('h300, 'hA00, 2'd2, 80);
        run(1'b1, n);
        check("b2b_first_cycles", n, FRAME_CYC);
        setup('h500, 'hC00, 2'd0, 0);
        @(negedge clk);
        check("b2b_busy_gap", {busy, done}, 2'b00);
        run(1'b0, n);
        check("b2b_second_cycles", n, FRAME_CYC);
        @(negedge clk);
        check("b2b_busy_after", busy, 1'b0);
        verify("b2b");
        check("final_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sobel_mm_engine.md
# sobel_mm_engine

Parametrised Sobel edge-detection engine for the image-processing subsystem: an Avalon-MM slave-controlled, Avalon-MM master-driven block that streams a row-major IMG_W×IMG_H greyscale image from memory, reads each pixel exactly once through two line buffers, and writes a packed (IMG_W-2)×(IMG_H-2) gradient image back. It is the next-generation replacement for the fixed 256×256, 9-reads-per-pixel engine. It adds:
- generic image geometry and pixel width;
- waitrequest handling;
- selectable output modes (half-scaled, full-scale, thresholded).

## Interface
Parameters:
- IMG_W, 256: image width in pixels (≥3).
- IMG_H, 256: image height in pixels (≥3).
- PIX_W, 8: pixel width in bits (1..16); byte stride per pixel is BPP=(PIX_W+7)/8.
- ADDR_W, 32: master address width.

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- go  in  1  start request, level-sampled in IDLE.
- in_base  in  ADDR_W  byte address of input pixel (0,0).
- out_base  in  ADDR_W  byte address of output pixel (0,0).
- mode  in  2  0=half-scaled clamp, 1=full clamp, 2=threshold, 3=treated as 0.
- threshold  in  PIX_W+3  compare value for mode 2.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse when the last write is accepted.
- address  out  ADDR_W  master byte address.
- read  out  1  master read request.
- write  out  1  master write request.
- writedata  out  PIX_W  output pixel.
- readdata  in  PIX_W  valid exactly 1 cycle after an accepted read.
- waitrequest  in  1  slave stall; a request is accepted when it is asserted and waitrequest=0.

## Operation
- Reset values: busy=0, done=0, read=0, write=0, address=0, writedata=0. Reset also clears the FSM, counters, window registers and line-buffer contents; no memory is written.
- Start:
  - In IDLE with go=1, latch in_base, out_base, mode and threshold.
  - Clear x and y, set busy=1, go to READ.
  - go is ignored while busy.
- FSM states:
  - IDLE.
  - READ: read=1, address=in_base+(y·IMG_W+x)·BPP, held until accepted.
  - CAPTURE: 1 cycle. Latch readdata. Push column {lb_top[x], lb_mid[x], readdata} into the 3×3 window. Update line buffers: lb_top[x]←lb_mid[x], lb_mid[x]←readdata.
  - CALC: 1 cycle, compute Gx and Gy.
  - WRITE: write=1, held until accepted.
  - DONE: 1 cycle, done=1, then IDLE.
- Window rule:
  - After CAPTURE of (x,y) with x≥2 and y≥2, go to CALC, then WRITE output pixel (x-2,y-2) at out_base+((y-2)·(IMG_W-2)+(x-2))·BPP.
  - Otherwise advance to READ.
- Advance: x wraps at IMG_W-1 to 0 and y increments. After the write for (IMG_W-1, IMG_H-1), go to DONE.
- Arithmetic, window p[r][c], r=0 top, c=0 left:
  - Gx = (p00+2p10+p20) − (p02+2p12+p22).
  - Gy = (p00+2p01+p02) − (p20+2p21+p22).
  - Gx and Gy are signed PIX_W+3 bits.
  - S = |Gx|+|Gy|, unsigned PIX_W+3 bits, never overflows.
- Output by mode (MAX = 2^PIX_W−1):
  - mode 0: min(S>>1, MAX).
  - mode 1: min(S, MAX).
  - mode 2: S≥threshold ? MAX : 0.
- Master rules:
  - read and write are never both high.
  - address and writedata stay stable while waitrequest=1.
  - address returns to 0 whenever neither request is active.
- Reset mid-operation aborts immediately; any in-flight request is dropped.

## Timing
- Per input pixel: READ (1 + stall cycles), then CAPTURE (1).
- Per output pixel: an extra CALC (1) and WRITE (1 + stall cycles).
- With no stalls, a full frame takes 2·IMG_W·IMG_H + 2·(IMG_W−2)(IMG_H−2) + 2 cycles from go sample to the done cycle, including IDLE→READ and DONE.
- busy falls in the cycle after done. go may be reasserted then for a back-to-back frame; the next frame starts 1 cycle later.

## Structure
- Package sobel_pkg holds:
  - the state enum (IDLE, READ, CAPTURE, CALC, WRITE, DONE);
  - the mode encodings;
  - the BPP and gradient-width functions of PIX_W.
- Sub-module sobel_line_buffer:
  - two IMG_W×PIX_W arrays with a combinational read at index x;
  - a single write-enable updating both rows at x;
  - asynchronous clear on rst.

## Test plan
- Vertical edge, IMG_W=IMG_H=4, PIX_W=8, mode 0, columns 0,0,255,255 → 16 reads, 4 writes to out_base+0..3, all 255; done pulses once; busy drops the next cycle.
- Uniform image of 100s, mode 1 → every output is 0; read addresses equal in_base+0..15 in order.
- Horizontal ramp with rows 10,20,30,40, mode 2, threshold=80 → S=80 everywhere, all outputs 255. Repeat with threshold=81 → all outputs 0.
- Random waitrequest (≈50%) on 8×6 random image → outputs match the reference model bit-exactly, requests stay stable under stall, read and write never overlap.
- rst deasserted, then asserted mid-frame during WRITE → all outputs return to reset values within the same cycle. A new go afterwards produces a correct full frame with no stale line-buffer data.
- go held high across done → a second frame starts, with the registers re-latched from the new in_base, out_base and mode values.
